// File: rtl/osc_phase_accum.sv
// osc_phase_accum -- time-multiplexed oscillator phase accumulator bank.
//
// One ACC_WIDTH-bit phase register per voice x oscillator. The slot tag on
// xxxx is delayed PITCH_LAT cycles so it lines up with osc_pitch_val. On the
// first sub-slot (oe == 0) of a valid, in-range tag, the addressed register is
// advanced by the increment through one shared adder. A synchronized note-on
// marks all oscillators of the keyed voice as pending. Each pending
// oscillator with sync_en set is zeroed at its next update.
//
// Ports
//   sCLK_XVXOSC    in   slot clock, rising edge
//   reset_data_N   in   async active-low reset
//   xxxx           in   slot tag {vx, ox, oe}
//   osc_pitch_val  in   24-bit increment aligned to the tag PITCH_LAT cycles back
//   note_on        in   async note-on level (held >= 3 clocks)
//   cur_key_adr    in   voice being started, stable while note_on high
//   sync_en        in   per-oscillator key-sync enable
//   osc_phase      out  top 16 bits of the updated accumulator
//   phase_vx/ox    out  voice / oscillator of osc_phase
//   phase_valid    out  one-cycle strobe per update
//   phase_wrap     out  carry out of the update

// Per-lane state: one accumulator and its key-sync pending flag.
module osc_phase_cell #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 sCLK_XVXOSC,
  input  logic                 reset_data_N,
  input  logic                 upd_i,     // this lane is being serviced
  input  logic [ACC_WIDTH-1:0] wdata_i,   // new accumulator value
  input  logic                 set_i,     // note-on edge for this voice
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 pend_o
);
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 pend_q, pend_d;

  // A note edge arriving in the same cycle as service must not be lost, so
  // set dominates the clear; the reset then happens on the next pass.
  always_comb begin
    acc_d  = upd_i ? wdata_i : acc_q;
    pend_d = set_i ? 1'b1 : (upd_i ? 1'b0 : pend_q);
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N)
    if (!reset_data_N) begin
      acc_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      pend_q <= pend_d;
    end

  assign acc_o  = acc_q;
  assign pend_o = pend_q;
endmodule

module osc_phase_accum #(
  parameter int VOICES    = 8,
  parameter int V_OSC     = 4,
  parameter int V_WIDTH   = 3,
  parameter int O_WIDTH   = 2,
  parameter int OE_WIDTH  = 1,
  parameter int E_WIDTH   = O_WIDTH + OE_WIDTH,
  parameter int PITCH_LAT = 3,
  parameter int ACC_WIDTH = 32
) (
  input  logic                       sCLK_XVXOSC,
  input  logic                       reset_data_N,
  input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  input  logic [23:0]                osc_pitch_val,
  input  logic                       note_on,
  input  logic [V_WIDTH-1:0]         cur_key_adr,
  input  logic [V_OSC-1:0]           sync_en,
  output logic [15:0]                osc_phase,
  output logic [V_WIDTH-1:0]         phase_vx,
  output logic [O_WIDTH-1:0]         phase_ox,
  output logic                       phase_valid,
  output logic                       phase_wrap
);
  localparam int TAG_W = V_WIDTH + E_WIDTH;
  localparam int NCELL = VOICES * V_OSC;

  // ---------------- tag delay line ----------------
  // vld_pipe_q marks stages holding a tag sampled since reset release, so the
  // zeroed delay line never looks like a real {0,0,0} tag.
  logic [PITCH_LAT-1:0][TAG_W-1:0] tag_q;
  logic [PITCH_LAT-1:0]            vld_pipe_q;

  always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N)
    if (!reset_data_N) begin
      tag_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      tag_q[0]      <= xxxx;
      vld_pipe_q[0] <= 1'b1;
      for (int i = 1; i < PITCH_LAT; i++) begin
        tag_q[i]      <= tag_q[i-1];
        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end

  logic [TAG_W-1:0]    tag_d;
  logic [V_WIDTH-1:0]  vd;
  logic [O_WIDTH-1:0]  od;
  logic [OE_WIDTH-1:0] oed;

  assign tag_d = tag_q[PITCH_LAT-1];
  assign vd    = tag_d[TAG_W-1 -: V_WIDTH];
  assign od    = tag_d[E_WIDTH-1 -: O_WIDTH];
  assign oed   = tag_d[OE_WIDTH-1:0];

  // ---------------- note-on synchronizer ----------------
  logic [1:0] note_sync_q;
  logic       note_prev_q;
  logic       key_edge;

  always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N)
    if (!reset_data_N) begin
      note_sync_q <= '0;
      note_prev_q <= 1'b0;
    end else begin
      note_sync_q <= {note_sync_q[0], note_on};
      note_prev_q <= note_sync_q[1];
    end

  assign key_edge = note_sync_q[1] & ~note_prev_q;

  // ---------------- accumulator lanes ----------------
  // A tag outside VOICES x V_OSC hits no lane, which is what suppresses the
  // update and the strobe for out-of-range tags.
  logic [NCELL-1:0]                hit;
  logic [NCELL-1:0]                set_v;
  logic [NCELL-1:0]                sen_v;
  logic [NCELL-1:0]                pend_v;
  logic [NCELL-1:0][ACC_WIDTH-1:0] acc_v;
  logic                            upd;
  logic [ACC_WIDTH-1:0]            acc_wr;

  assign upd = vld_pipe_q[PITCH_LAT-1] && (oed == '0) && (|hit);

  for (genvar gv = 0; gv < VOICES; gv++) begin : g_v
    for (genvar go = 0; go < V_OSC; go++) begin : g_o
      localparam int IDX = gv * V_OSC + go;
      assign hit[IDX]   = (vd == V_WIDTH'(gv)) && (od == O_WIDTH'(go));
      assign set_v[IDX] = key_edge && (cur_key_adr == V_WIDTH'(gv));
      assign sen_v[IDX] = sync_en[go];

      osc_phase_cell #(.ACC_WIDTH(ACC_WIDTH)) u_cell (
        .sCLK_XVXOSC  (sCLK_XVXOSC),
        .reset_data_N (reset_data_N),
        .upd_i        (upd && hit[IDX]),
        .wdata_i      (acc_wr),
        .set_i        (set_v[IDX]),
        .acc_o        (acc_v[IDX]),
        .pend_o       (pend_v[IDX])
      );
    end
  end

  // ---------------- shared read / add ----------------
  logic [ACC_WIDTH-1:0] acc_rd;
  logic                 pend_rd;
  logic                 sen_rd;
  logic [ACC_WIDTH:0]   sum;
  logic                 do_sync;
  logic                 wrap_d;

  always_comb begin
    acc_rd  = '0;
    pend_rd = 1'b0;
    sen_rd  = 1'b0;
    for (int i = 0; i < NCELL; i++)
      if (hit[i]) begin
        acc_rd  = acc_v[i];
        pend_rd = pend_v[i];
        sen_rd  = sen_v[i];
      end
  end

  assign sum     = {1'b0, acc_rd} + {{(ACC_WIDTH + 1 - 24){1'b0}}, osc_pitch_val};
  assign do_sync = pend_rd & sen_rd;
  assign acc_wr  = do_sync ? '0 : sum[ACC_WIDTH-1:0];
  assign wrap_d  = ~do_sync & sum[ACC_WIDTH];

  // ---------------- output register ----------------
  logic [15:0]        osc_phase_q;
  logic [V_WIDTH-1:0] phase_vx_q;
  logic [O_WIDTH-1:0] phase_ox_q;
  logic               phase_valid_q;
  logic               phase_wrap_q;

  always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N)
    if (!reset_data_N) begin
      osc_phase_q   <= '0;
      phase_vx_q    <= '0;
      phase_ox_q    <= '0;
      phase_valid_q <= 1'b0;
      phase_wrap_q  <= 1'b0;
    end else begin
      phase_valid_q <= upd;
      if (upd) begin
        osc_phase_q  <= acc_wr[ACC_WIDTH-1 -: 16];
        phase_vx_q   <= vd;
        phase_ox_q   <= od;
        phase_wrap_q <= wrap_d;
      end
    end

  assign osc_phase   = osc_phase_q;
  assign phase_vx    = phase_vx_q;
  assign phase_ox    = phase_ox_q;
  assign phase_valid = phase_valid_q;
  assign phase_wrap  = phase_wrap_q;
endmodule

// File: tb/tb_osc_phase_accum.sv
// tb_osc_phase_accum -- directed bench for osc_phase_accum.
// Slot passes are driven as full {v, o, oe} sweeps. The increment for each
// slot is driven PITCH_LAT cycles after its tag. A negedge monitor records
// the latest phase/wrap per slot and the strobe counts. A table of
// hand-computed {slot, phase, wrap} expectations is then compared per group.
module tb_osc_phase_accum;
  localparam int PL = 3;
  localparam logic [5:0] IDLE_TAG = 6'b000_00_1;

  logic        clk = 1'b0;
  logic        reset_data_N;
  logic [5:0]  xxxx;
  logic [23:0] osc_pitch_val;
  logic        note_on;
  logic [2:0]  cur_key_adr;
  logic [3:0]  sync_en;
  logic [15:0] osc_phase;
  logic [2:0]  phase_vx;
  logic [1:0]  phase_ox;
  logic        phase_valid;
  logic        phase_wrap;

  osc_phase_accum dut (
    .sCLK_XVXOSC   (clk),
    .reset_data_N  (reset_data_N),
    .xxxx          (xxxx),
    .osc_pitch_val (osc_pitch_val),
    .note_on       (note_on),
    .cur_key_adr   (cur_key_adr),
    .sync_en       (sync_en),
    .osc_phase     (osc_phase),
    .phase_vx      (phase_vx),
    .phase_ox      (phase_ox),
    .phase_valid   (phase_valid),
    .phase_wrap    (phase_wrap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus ----------------
  typedef enum int {M_CONST, M_ALIGN, M_WRAP} mode_t;
  mode_t      mode = M_CONST;
  logic [5:0] hist [0:PL];

  // oe != 0 slots get a junk increment: it must never reach an accumulator.
  // Alignment uses {v,o} << 19 so each slot lands in a distinct osc_phase.
  function automatic logic [23:0] pitch_of(input logic [5:0] tag);
    if (tag[0]) return 24'hABCDEF;
    case (mode)
      M_CONST: return 24'h100000;
      M_ALIGN: return 24'(tag[5:1]) << 19;
      default: return (tag[5:3] == 3'd2 && tag[2:1] == 2'd1) ? 24'hFFFFFF : 24'h0;
    endcase
  endfunction

  task automatic tick(input logic [5:0] tag);
    @(posedge clk); #1;
    for (int i = PL; i > 0; i--) hist[i] = hist[i-1];
    hist[0]       = tag;
    xxxx          = tag;
    osc_pitch_val = pitch_of(hist[PL]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(IDLE_TAG);
  endtask

  task automatic run_passes(input int n);
    for (int p = 0; p < n; p++)
      for (int v = 0; v < 8; v++)
        for (int o = 0; o < 4; o++)
          for (int e = 0; e < 2; e++)
            tick({3'(v), 2'(o), 1'(e)});
  endtask

  task automatic do_reset();
    reset_data_N = 1'b0;
    idle(3);
    reset_data_N = 1'b1;
    idle(3);
  endtask

  // ---------------- monitor ----------------
  logic [15:0] obs_phase [0:31];
  logic        obs_wrap  [0:31];
  int          strobe_cnt[0:31];
  int          n_strobe, n_wrap, first_cyc;

  always @(negedge clk)
    if (reset_data_N && phase_valid) begin
      obs_phase[{phase_vx, phase_ox}] = osc_phase;
      obs_wrap[{phase_vx, phase_ox}]  = phase_wrap;
      strobe_cnt[{phase_vx, phase_ox}]++;
      n_strobe++;
      if (phase_wrap) n_wrap++;
      if (first_cyc < 0) first_cyc = cyc;
    end

  task automatic clear_obs();
    for (int i = 0; i < 32; i++) begin
      obs_phase[i]  = 'x;
      obs_wrap[i]   = 1'bx;
      strobe_cnt[i] = 0;
    end
    n_strobe  = 0;
    n_wrap    = 0;
    first_cyc = -1;
  endtask

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs_zero(input string nm);
    check(nm, 32'({osc_phase, phase_vx, phase_ox, phase_valid, phase_wrap}), 32'h0);
  endtask

  typedef struct {
    int          grp;
    int          v;
    int          o;
    logic [15:0] ph;
    logic        wr;
  } vec_t;
  vec_t vecs[$];

  task automatic apply_group(input int grp);
    foreach (vecs[i])
      if (vecs[i].grp == grp) begin
        check($sformatf("g%0d v%0d o%0d phase", grp, vecs[i].v, vecs[i].o),
              32'(obs_phase[vecs[i].v*4 + vecs[i].o]), 32'(vecs[i].ph));
        check($sformatf("g%0d v%0d o%0d wrap", grp, vecs[i].v, vecs[i].o),
              32'(obs_wrap[vecs[i].v*4 + vecs[i].o]), 32'(vecs[i].wr));
      end
  endtask

  int tag_cyc;

  initial begin
    // group 1: 5 passes of 0x100000 -> 0x00500000
    vecs.push_back('{1, 0, 0, 16'h0050, 1'b0});
    vecs.push_back('{1, 2, 1, 16'h0050, 1'b0});
    vecs.push_back('{1, 5, 3, 16'h0050, 1'b0});
    vecs.push_back('{1, 7, 3, 16'h0050, 1'b0});
    // group 2: one pass of {v,o}<<19 -> phase {v,o}<<3
    vecs.push_back('{2, 0, 1, 16'h0008, 1'b0});
    vecs.push_back('{2, 2, 1, 16'h0048, 1'b0});
    vecs.push_back('{2, 3, 0, 16'h0060, 1'b0});
    vecs.push_back('{2, 5, 2, 16'h00B0, 1'b0});
    vecs.push_back('{2, 7, 3, 16'h00F8, 1'b0});
    // group 3: 256 x 0xFFFFFF = 0xFFFFFF00, no carry; v2/o0 stays 0
    vecs.push_back('{3, 2, 1, 16'hFFFF, 1'b0});
    vecs.push_back('{3, 2, 0, 16'h0000, 1'b0});
    // group 4: update 257 -> 0x00FFFEFF with carry
    vecs.push_back('{4, 2, 1, 16'h00FF, 1'b1});
    // group 5: key sync v5, sync_en 0101, after 2 passes of 0x100000
    vecs.push_back('{5, 5, 0, 16'h0000, 1'b0});
    vecs.push_back('{5, 5, 2, 16'h0000, 1'b0});
    vecs.push_back('{5, 5, 1, 16'h0030, 1'b0});
    vecs.push_back('{5, 5, 3, 16'h0030, 1'b0});
    vecs.push_back('{5, 4, 0, 16'h0030, 1'b0});
    vecs.push_back('{5, 6, 2, 16'h0030, 1'b0});
    // group 6: following pass, synced oscs restart from 0, sync not repeated
    vecs.push_back('{6, 5, 0, 16'h0010, 1'b0});
    vecs.push_back('{6, 5, 2, 16'h0010, 1'b0});
    vecs.push_back('{6, 5, 1, 16'h0040, 1'b0});
    vecs.push_back('{6, 4, 0, 16'h0040, 1'b0});
    // group 7: first pass after mid-run reset; stale v3 sync must be gone
    vecs.push_back('{7, 3, 0, 16'h0010, 1'b0});
    vecs.push_back('{7, 3, 3, 16'h0010, 1'b0});
    vecs.push_back('{7, 0, 0, 16'h0010, 1'b0});
    vecs.push_back('{7, 7, 3, 16'h0010, 1'b0});

    reset_data_N  = 1'b0;
    note_on       = 1'b0;
    cur_key_adr   = '0;
    sync_en       = '0;
    xxxx          = IDLE_TAG;
    osc_pitch_val = '0;
    for (int i = 0; i <= PL; i++) hist[i] = IDLE_TAG;
    clear_obs();

    // ---- reset state and first-strobe latency ----
    tick(6'b000_00_0);
    tick(6'b000_01_0);
    idle(3);
    check_outs_zero("reset outputs");
    reset_data_N = 1'b1;
    idle(3);
    clear_obs();
    tick(6'b000_00_0);
    tag_cyc = cyc;
    idle(8);
    check("first strobe latency", 32'(first_cyc - tag_cyc), 32'(PL + 1));
    check("single strobe count", 32'(n_strobe), 32'd1);
    check("first strobe phase", 32'(obs_phase[0]), 32'h0010);

    // ---- accumulation ----
    do_reset();
    mode = M_CONST;
    clear_obs();
    run_passes(5);
    idle(8);
    check("accum total strobes", 32'(n_strobe), 32'd160);
    check("accum strobes v0o0", 32'(strobe_cnt[0]), 32'd5);
    check("accum strobes v7o3", 32'(strobe_cnt[31]), 32'd5);
    apply_group(1);

    // ---- alignment ----
    do_reset();
    mode = M_ALIGN;
    clear_obs();
    run_passes(1);
    idle(8);
    apply_group(2);

    // ---- wrap ----
    do_reset();
    mode = M_WRAP;
    clear_obs();
    run_passes(256);
    idle(8);
    check("no wrap in 256 updates", 32'(n_wrap), 32'd0);
    apply_group(3);
    clear_obs();
    run_passes(1);
    idle(8);
    check("wrap on update 257", 32'(n_wrap), 32'd1);
    apply_group(4);

    // ---- key sync ----
    do_reset();
    mode = M_CONST;
    run_passes(2);
    idle(4);
    cur_key_adr = 3'd5;
    sync_en     = 4'b0101;
    note_on     = 1'b1;
    idle(4);
    note_on = 1'b0;
    idle(4);
    clear_obs();
    run_passes(1);
    idle(8);
    apply_group(5);
    clear_obs();
    run_passes(1);
    idle(8);
    apply_group(6);

    // ---- reset mid-run with a pending sync ----
    do_reset();
    run_passes(1);
    idle(4);
    cur_key_adr = 3'd3;
    sync_en     = 4'b1111;
    note_on     = 1'b1;
    idle(4);
    note_on = 1'b0;
    idle(2);
    for (int i = 0; i < 20; i++) tick({3'(i / 8), 2'((i / 2) % 4), 1'(i % 2)});
    reset_data_N = 1'b0;
    idle(2);
    check_outs_zero("mid-run reset outputs");
    reset_data_N = 1'b1;
    idle(3);
    clear_obs();
    run_passes(1);
    idle(8);
    check("post-reset strobes", 32'(n_strobe), 32'd32);
    apply_group(7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
